game_round_sequencer: RTL and testbench

GAME_ROUND_SEQUENCER -- requirements
Module: game_round_sequencer

---
 rtl/game_round_sequencer_pkg.sv | 37 +++
 rtl/game_round_sequencer_if.sv | 32 +++
 rtl/game_round_sequencer_edge_detect.sv | 26 ++
 rtl/game_round_sequencer.sv | 130 +++++++++++++
 tb/tb_game_round_sequencer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/game_round_sequencer_pkg.sv
// Shared definitions for the game round sequencer: default parameter values,
// output widths, the one-hot state encoding and the saturating score adder.
package game_pkg;

  localparam int unsigned DEF_NUM_ROUNDS   = 4;
  localparam int unsigned DEF_NUM_LIVES    = 3;
  localparam int unsigned DEF_ROUND_POINTS = 100;
  localparam int unsigned DEF_ROUND_TIME   = 60;

  localparam int unsigned STATE_W = 6;
  localparam int unsigned ROUND_W = 4;
  localparam int unsigned LIVES_W = 4;
  localparam int unsigned SCORE_W = 16;
  localparam int unsigned TIME_W  = 10;
  localparam int unsigned WON_W   = 16;

  localparam logic [32:0] SCORE_MAX = 33'h0_0000_FFFF;

  // One-hot encoding; bit position equals state order.
  typedef enum logic [STATE_W-1:0] {
    INIT  = 6'b000001,
    PLAY  = 6'b000010,
    RDONE = 6'b000100,
    HIT   = 6'b001000,
    LOSE  = 6'b010000,
    WIN   = 6'b100000
  } state_t;

  // Score addition clamped at the top of the 16-bit display range.
  function automatic logic [SCORE_W-1:0] satAdd(input logic [SCORE_W-1:0] a,
                                                input logic [31:0] b);
    logic [32:0] sum;
    sum = 33'(a) + 33'(b);
    return (sum > SCORE_MAX) ? 16'hFFFF : 16'(sum);
  endfunction

endpackage

// File: rtl/game_round_sequencer_if.sv
// Player-control inputs and game-status outputs of the round sequencer.
//   master: drives Start, Ack, roundWon, collidedWithEnemy, secTick
//   slave : drives state, round, lives, score, timeLeft, roundStart
interface game_round_sequencer_if
  import game_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = DEF_NUM_ROUNDS
) ();

  logic                  Start;
  logic                  Ack;
  logic [NUM_ROUNDS-1:0] roundWon;
  logic                  collidedWithEnemy;
  logic                  secTick;
  logic [STATE_W-1:0]    state;
  logic [ROUND_W-1:0]    round;
  logic [LIVES_W-1:0]    lives;
  logic [SCORE_W-1:0]    score;
  logic [TIME_W-1:0]     timeLeft;
  logic                  roundStart;

  modport master (
    output Start, Ack, roundWon, collidedWithEnemy, secTick,
    input  state, round, lives, score, timeLeft, roundStart
  );

  modport slave (
    input  Start, Ack, roundWon, collidedWithEnemy, secTick,
    output state, round, lives, score, timeLeft, roundStart
  );

endinterface

// File: rtl/game_round_sequencer_edge_detect.sv
// Registered rising-edge pulser.
//   Clk, Reset_n : clock, async active-low reset (history cleared to 0)
//   d            : level input
//   pulse        : one-cycle high the cycle after d rises
module edge_detect (
  input  logic Clk,
  input  logic Reset_n,
  input  logic d,
  output logic pulse
);

  logic dQ;

  // Pulse is registered, so an input already high at reset release is seen
  // by downstream logic no earlier than the second clock edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dQ    <= 1'b0;
      pulse <= 1'b0;
    end else begin
      dQ    <= d;
      pulse <= d & ~dQ;
    end
  end

endmodule

// File: rtl/game_round_sequencer.sv
// Game round sequencer: walks a game through rounds, tracking round index,
// lives, score and per-round countdown.
//   Clk, Reset_n : clock, async active-low reset
//   bus (slave)  : Start/Ack switch levels, roundWon flags, collision flag,
//                  1 Hz secTick in; registered one-hot state, round, lives,
//                  score, timeLeft and roundStart pulse out
module game_round_sequencer
  import game_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS   = DEF_NUM_ROUNDS,
  parameter int unsigned NUM_LIVES    = DEF_NUM_LIVES,
  parameter int unsigned ROUND_POINTS = DEF_ROUND_POINTS,
  parameter int unsigned ROUND_TIME   = DEF_ROUND_TIME
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  game_round_sequencer_if.slave bus
);

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(NUM_LIVES);
  localparam logic [TIME_W-1:0]  TIME_INIT  = TIME_W'(ROUND_TIME);

  logic startRise, ackRise;

  edge_detect uStartEdge (.Clk(Clk), .Reset_n(Reset_n), .d(bus.Start), .pulse(startRise));
  edge_detect uAckEdge   (.Clk(Clk), .Reset_n(Reset_n), .d(bus.Ack),   .pulse(ackRise));

  state_t               stateQ, stateD;
  logic [ROUND_W-1:0]   roundQ, roundD;
  logic [LIVES_W-1:0]   livesQ, livesD;
  logic [SCORE_W-1:0]   scoreQ, scoreD;
  logic [TIME_W-1:0]    timeQ, timeD;
  logic                 roundStartQ, roundStartD;

  logic [WON_W-1:0]     wonVec;
  logic                 roundWinNow;
  logic [31:0]          roundPoints;

  // Only the flag of the current round matters; pad so the 4-bit index fits.
  assign wonVec      = WON_W'(bus.roundWon);
  assign roundWinNow = wonVec[roundQ];
  assign roundPoints = ROUND_POINTS * (32'(roundQ) + 32'd1);

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stateQ      <= INIT;
      roundQ      <= '0;
      livesQ      <= LIVES_INIT;
      scoreQ      <= '0;
      timeQ       <= TIME_INIT;
      roundStartQ <= 1'b0;
    end else begin
      stateQ      <= stateD;
      roundQ      <= roundD;
      livesQ      <= livesD;
      scoreQ      <= scoreD;
      timeQ       <= timeD;
      roundStartQ <= roundStartD;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    stateD      = stateQ;
    roundD      = roundQ;
    livesD      = livesQ;
    scoreD      = scoreQ;
    timeD       = timeQ;
    roundStartD = 1'b0;

    case (stateQ)
      INIT: begin
        // Score is left alone until Start so the last result stays shown.
        if (startRise) begin
          stateD      = PLAY;
          roundD      = '0;
          livesD      = LIVES_INIT;
          scoreD      = '0;
          timeD       = TIME_INIT;
          roundStartD = 1'b1;
        end
      end
      PLAY: begin
        // A win in the same cycle as a collision or timeout takes priority.
        if (roundWinNow) begin
          stateD = RDONE;
          scoreD = satAdd(scoreQ, roundPoints);
        end else if (bus.collidedWithEnemy || (timeQ == '0)) begin
          stateD = HIT;
          if (livesQ != '0) livesD = livesQ - 4'd1;
        end else if (bus.secTick) begin
          timeD = timeQ - 10'd1;
        end
      end
      RDONE: begin
        if (roundQ == LAST_ROUND) begin
          stateD = WIN;
        end else if (ackRise) begin
          stateD      = PLAY;
          roundD      = roundQ + 4'd1;
          timeD       = TIME_INIT;
          roundStartD = 1'b1;
        end
      end
      HIT: begin
        if (livesQ == '0) begin
          stateD = LOSE;
        end else if (ackRise && !bus.collidedWithEnemy) begin
          stateD      = PLAY;
          timeD       = TIME_INIT;
          roundStartD = 1'b1;
        end
      end
      LOSE, WIN: begin
        if (ackRise) stateD = INIT;
      end
      default: stateD = INIT;
    endcase
  end

  assign bus.state      = stateQ;
  assign bus.round      = roundQ;
  assign bus.lives      = livesQ;
  assign bus.score      = scoreQ;
  assign bus.timeLeft   = timeQ;
  assign bus.roundStart = roundStartQ;

endmodule

// File: tb/tb_game_round_sequencer.sv
// Directed bench for game_round_sequencer: three instances (defaults,
// short round timer, high points with three rounds) share one stimulus set.
module tb_game_round_sequencer;
  import game_pkg::*;

  logic       clk;
  logic       rstN;
  logic       start, ack, coll, tick;
  logic [3:0] won;

  int nChecks = 0;
  int nFail   = 0;

  game_round_sequencer_if #(.NUM_ROUNDS(4)) ifA ();
  game_round_sequencer_if #(.NUM_ROUNDS(4)) ifB ();
  game_round_sequencer_if #(.NUM_ROUNDS(3)) ifC ();

  assign ifA.Start = start;  assign ifB.Start = start;  assign ifC.Start = start;
  assign ifA.Ack   = ack;    assign ifB.Ack   = ack;    assign ifC.Ack   = ack;
  assign ifA.collidedWithEnemy = coll;
  assign ifB.collidedWithEnemy = coll;
  assign ifC.collidedWithEnemy = coll;
  assign ifA.secTick = tick; assign ifB.secTick = tick; assign ifC.secTick = tick;
  assign ifA.roundWon = won;
  assign ifB.roundWon = won;
  assign ifC.roundWon = won[2:0];

  game_round_sequencer dutA (.Clk(clk), .Reset_n(rstN), .bus(ifA));
  game_round_sequencer #(.ROUND_TIME(2)) dutB (.Clk(clk), .Reset_n(rstN), .bus(ifB));
  game_round_sequencer #(.NUM_ROUNDS(3), .ROUND_POINTS(30000))
    dutC (.Clk(clk), .Reset_n(rstN), .bus(ifC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       ack;
    logic [3:0] won;
    logic       coll;
    int         cycles;
    state_t     expState;
    logic [3:0] expRound;
    logic [3:0] expLives;
    logic [15:0] expScore;
    logic [9:0] expTime;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic a, logic [3:0] w, logic c, int cyc,
                              state_t st, int r, int l, int sc, int t);
    vec_t v;
    v.start = s; v.ack = a; v.won = w; v.coll = c; v.cycles = cyc;
    v.expState = st;
    v.expRound = 4'(r);
    v.expLives = 4'(l);
    v.expScore = 16'(sc);
    v.expTime  = 10'(t);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset(input logic startLvl);
    rstN = 1'b0;
    start = startLvl; ack = 1'b0; won = 4'd0; coll = 1'b0; tick = 1'b0;
    step(2);
    rstN = 1'b1;
  endtask

  initial begin
    int rsCount;
    rstN = 1'b0;

    // Start held through reset: no action before the second edge after release.
    doReset(1'b1);
    check("rst.state", 32'(ifA.state), 32'(INIT));
    check("rst.round", 32'(ifA.round), 0);
    check("rst.lives", 32'(ifA.lives), 3);
    check("rst.score", 32'(ifA.score), 0);
    check("rst.time",  32'(ifA.timeLeft), 60);
    check("rst.roundStart", 32'(ifA.roundStart), 0);
    step(1);
    check("release.edge1.state", 32'(ifA.state), 32'(INIT));
    step(1);
    check("release.edge2.state", 32'(ifA.state), 32'(PLAY));
    check("release.edge2.roundStart", 32'(ifA.roundStart), 1);
    step(1);
    check("release.edge3.roundStart", 32'(ifA.roundStart), 0);

    // Table: full win game then a full loss game on the default instance.
    vecs.push_back(mk(1, 0, 4'b0000, 0, 3, PLAY,  0, 3,    0, 60));
    vecs.push_back(mk(0, 0, 4'b0001, 0, 3, RDONE, 0, 3,  100, 60));
    vecs.push_back(mk(0, 1, 4'b0001, 0, 3, PLAY,  1, 3,  100, 60));
    vecs.push_back(mk(0, 0, 4'b0011, 0, 3, RDONE, 1, 3,  300, 60));
    vecs.push_back(mk(0, 1, 4'b0011, 0, 3, PLAY,  2, 3,  300, 60));
    vecs.push_back(mk(0, 0, 4'b0111, 0, 3, RDONE, 2, 3,  600, 60));
    vecs.push_back(mk(0, 1, 4'b0111, 0, 3, PLAY,  3, 3,  600, 60));
    vecs.push_back(mk(0, 0, 4'b1111, 0, 1, RDONE, 3, 3, 1000, 60));
    vecs.push_back(mk(0, 0, 4'b1111, 0, 1, WIN,   3, 3, 1000, 60));
    vecs.push_back(mk(0, 1, 4'b0000, 0, 3, INIT,  3, 3, 1000, 60));
    vecs.push_back(mk(1, 0, 4'b0000, 0, 3, PLAY,  0, 3,    0, 60));
    vecs.push_back(mk(0, 0, 4'b0000, 1, 3, HIT,   0, 2,    0, 60));
    vecs.push_back(mk(0, 1, 4'b0000, 0, 3, PLAY,  0, 2,    0, 60));
    vecs.push_back(mk(0, 0, 4'b0000, 1, 3, HIT,   0, 1,    0, 60));
    vecs.push_back(mk(0, 1, 4'b0000, 0, 3, PLAY,  0, 1,    0, 60));
    vecs.push_back(mk(0, 0, 4'b0000, 1, 3, LOSE,  0, 0,    0, 60));
    vecs.push_back(mk(0, 1, 4'b0000, 0, 3, INIT,  0, 0,    0, 60));

    doReset(1'b0);
    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start; ack = vecs[i].ack; won = vecs[i].won; coll = vecs[i].coll;
      step(vecs[i].cycles);
      check($sformatf("vec%0d.state", i), 32'(ifA.state),    32'(vecs[i].expState));
      check($sformatf("vec%0d.round", i), 32'(ifA.round),    32'(vecs[i].expRound));
      check($sformatf("vec%0d.lives", i), 32'(ifA.lives),    32'(vecs[i].expLives));
      check($sformatf("vec%0d.score", i), 32'(ifA.score),    32'(vecs[i].expScore));
      check($sformatf("vec%0d.time",  i), 32'(ifA.timeLeft), 32'(vecs[i].expTime));
    end

    // Timeout with a two-tick round timer.
    doReset(1'b0);
    start = 1'b1; step(3); start = 1'b0;
    check("tmo.play.time", 32'(ifB.timeLeft), 2);
    tick = 1'b1; step(1); tick = 1'b0;
    check("tmo.tick1.time", 32'(ifB.timeLeft), 1);
    tick = 1'b1; step(1); tick = 1'b0;
    check("tmo.tick2.time", 32'(ifB.timeLeft), 0);
    step(1);
    check("tmo.hit.state", 32'(ifB.state), 32'(HIT));
    check("tmo.hit.lives", 32'(ifB.lives), 2);
    check("tmo.hit.time",  32'(ifB.timeLeft), 0);
    ack = 1'b1;
    rsCount = 0;
    for (int c = 0; c < 6; c++) begin
      step(1);
      if (ifB.roundStart === 1'b1) rsCount++;
    end
    ack = 1'b0;
    check("tmo.resume.state", 32'(ifB.state), 32'(PLAY));
    check("tmo.resume.time",  32'(ifB.timeLeft), 2);
    check("tmo.resume.roundStartPulses", 32'(rsCount), 1);

    // Win and collision together; Ack during a held collision in HIT.
    doReset(1'b0);
    start = 1'b1; step(3); start = 1'b0;
    won = 4'b0001; coll = 1'b1; step(1);
    check("simul.state", 32'(ifA.state), 32'(RDONE));
    check("simul.lives", 32'(ifA.lives), 3);
    check("simul.score", 32'(ifA.score), 100);
    won = 4'b0000; coll = 1'b0; ack = 1'b1; step(3);
    check("simul.next.round", 32'(ifA.round), 1);
    ack = 1'b0; coll = 1'b1; step(2);
    check("simul.hit.state", 32'(ifA.state), 32'(HIT));
    ack = 1'b1; step(4);
    check("simul.ackDuringColl.state", 32'(ifA.state), 32'(HIT));
    coll = 1'b0; step(3);
    check("simul.ackHeld.state", 32'(ifA.state), 32'(HIT));
    ack = 1'b0; step(1);
    ack = 1'b1; step(3); ack = 1'b0;
    check("simul.freshAck.state", 32'(ifA.state), 32'(PLAY));
    check("simul.freshAck.lives", 32'(ifA.lives), 2);

    // Score saturation with 30000 points per round over three rounds.
    doReset(1'b0);
    start = 1'b1; step(3); start = 1'b0;
    won = 4'b0001; step(1);
    check("sat.r0.score", 32'(ifC.score), 30000);
    ack = 1'b1; step(3); ack = 1'b0;
    check("sat.r1.round", 32'(ifC.round), 1);
    won = 4'b0011; step(1);
    check("sat.r1.score", 32'(ifC.score), 65535);
    ack = 1'b1; step(3); ack = 1'b0;
    won = 4'b0111; step(1);
    check("sat.r2.state", 32'(ifC.state), 32'(RDONE));
    check("sat.r2.score", 32'(ifC.score), 65535);
    step(1);
    check("sat.win.state", 32'(ifC.state), 32'(WIN));
    won = 4'b0000;

    // Asynchronous reset in the middle of round 2.
    doReset(1'b0);
    start = 1'b1; step(3); start = 1'b0;
    won = 4'b0001; step(1);
    won = 4'b0000; ack = 1'b1; step(3); ack = 1'b0;
    won = 4'b0010; step(1);
    won = 4'b0000; ack = 1'b1; step(3); ack = 1'b0;
    tick = 1'b1; step(1); tick = 1'b0;
    check("mid.state", 32'(ifA.state), 32'(PLAY));
    check("mid.round", 32'(ifA.round), 2);
    check("mid.score", 32'(ifA.score), 300);
    check("mid.time",  32'(ifA.timeLeft), 59);
    #3 rstN = 1'b0;
    #1;
    check("async.state", 32'(ifA.state), 32'(INIT));
    check("async.round", 32'(ifA.round), 0);
    check("async.lives", 32'(ifA.lives), 3);
    check("async.score", 32'(ifA.score), 0);
    check("async.time",  32'(ifA.timeLeft), 60);
    check("async.roundStart", 32'(ifA.roundStart), 0);
    step(1);
    rstN = 1'b1;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
